pulse_sched: RTL and testbench
==============================

# pulse_sched

Round-robin scheduler that shares one pulse2pulse clock-domain-crossing channel between N event sources in the source clock domain. It captures single-cycle event pulses from each requester and issues them one at a time to the channel's pulse input, with a sideband index. It enforces a programmable minimum spacing between issued pulses so the destination-domain synchronizer resolves every toggle. Lost events, meaning a second event from a requester whose previous event is still pending, are flagged per requester.

## Interface
- N, 4: number of requesters, 2..16
- IW, 2: index width, must equal clog2(N)
- GAP, 4: minimum clk cycles between consecutive `pulse` assertions, ≥1
- clk  in  1  source-domain clock; drives the channel's `clkin`
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- req  in  N  per-requester single-cycle event pulses
- ovf_clr  in  1  clears all `ovf` bits
- pulse  out  1  single-cycle pulse to the channel `din`
- sel  out  IW  index of the requester served by the latest `pulse`; held until the next `pulse`
- busy  out  1  spacing interval active; no new `pulse` possible next edge
- pending  out  N  captured, not-yet-issued events
- ovf  out  N  sticky lost-event flags

## Operation
- All state is registered: `pending`, `ovf`, `ptr`, `gap_cnt`, `pulse`, `sel`.
- **Reset values.** While `reset` is high, all outputs and internal state are 0 immediately, without waiting for a clock. Events pending at reset are discarded.
- **Capture.** `req[i]`=1 at an edge sets `pending[i]`.
- **Eligibility.** An edge is eligible when `gap_cnt`==0 and `|pending`.
- **Grant.** At an eligible edge, grant index g is the first set bit of `pending`, searching from `ptr` upward and wrapping N-1→0. At that edge:
  - `pulse`←1 and `sel`←g.
  - `pending[g]` clears, unless `req[g]` is also high that edge; then it stays 1 and the new event is kept, not dropped.
  - `ptr`←(g+1) mod N.
  - `gap_cnt`←GAP-1.
- **Non-eligible edge.** `pulse`←0 and `sel` holds. `gap_cnt` decrements if nonzero.
- **Overflow.** `req[i]`=1 while `pending[i]`=1 and i is not granted that edge sets `ovf[i]`. The event is dropped and no second pulse is issued for it.
- **ovf_clr.** Clears all `ovf` bits at the edge. If an overflow occurs on the same edge, the set wins for that bit.
- **busy** = (`gap_cnt`≠0), decoded combinationally from a register.
- **Counter width.** `gap_cnt` is clog2(GAP) bits, minimum 1. It never underflows: decrement only when nonzero.
- **Back-to-back.** GAP=1 allows a `pulse` on every cycle while requests are pending.
- **Simultaneous requests.** All captured together, issued in round-robin order from `ptr`.

## Timing
- Latency, idle case: `req[i]` high in cycle 0 → `pending[i]` high in cycle 1 → `pulse`=1 and `sel`=i in cycle 2.
- Width: `pulse` is exactly one cycle wide per grant.
- Spacing: consecutive pulses are exactly GAP cycles apart when requests are backlogged, and never fewer.
- `busy` is high for GAP-1 cycles starting in the cycle `pulse` is high.
- `sel` is valid in the cycle `pulse` is high and stable until the next pulse. The destination domain samples it only after its `dout`, which is ≥2 `clkout` cycles later. Integrators guarantee GAP·Tclk exceeds the channel's toggle-recovery time plus `sel` sampling time.
- Reset deassertion: first possible `pulse` is 2 cycles after the first `req`.

## Test plan
1. **Single event.** N=4, GAP=4; `req`=0b0100 in cycle 0 → `pending`=0b0100 in cycle 1; `pulse`=1 with `sel`=2 in cycle 2; `busy`=1 in cycles 2–4, 0 in cycle 5; no further pulses.
2. **All requesters at once.** `req`=0b1111 in cycle 0 → pulses in cycles 2, 6, 10, 14 with `sel`=0, 1, 2, 3; `pending` empties after cycle 14; `ovf`=0.
3. **Round-robin wrap.** After a grant to index 3, `req`=0b1001 → first pulse `sel`=0, then `sel`=3. After a grant to 1, `req`=0b0011 → `sel`=0 first (ptr=2 wraps to 0), then 1.
4. **Overflow.** `req[0]` in cycle 0, `req[1]` in cycles 3 and 4 while `busy` → one pulse with `sel`=1 in cycle 6; `ovf`=0b0010 from cycle 5. `ovf_clr` in cycle 8 → `ovf`=0 in cycle 9. `ovf_clr` on the same edge as a new `req[1]` overflow → `ovf[1]` stays 1.
5. **Same-edge request and grant.** GAP=1; `req[2]` in cycles 0 and 1 → pulses in cycles 2 and 3, both `sel`=2; `ovf`=0.
6. **Reset mid-operation.** Reach `pending`=0b1010 with `busy`=1, then assert `reset` mid-cycle → all outputs 0 before the next edge. Release `reset` with no `req` → no pulses for 20 cycles. Then `req`=0b0001 → pulse 2 cycles later with `sel`=0.

Source files
------------

// File: rtl/pulse_sched_if.sv
// Requester-side bundle for pulse_sched: event inputs, channel pulse/index outputs
// and the pending/overflow status vectors.
interface pulse_sched_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]  req;
    logic          ovf_clr;
    logic          pulse;
    logic [IW-1:0] sel;
    logic          busy;
    logic [N-1:0]  pending;
    logic [N-1:0]  ovf;

    modport master (
        output req, ovf_clr,
        input  pulse, sel, busy, pending, ovf
    );

    modport slave (
        input  req, ovf_clr,
        output pulse, sel, busy, pending, ovf
    );
endinterface

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one pulse2pulse CDC channel between N event sources,
// with a programmable minimum spacing between issued pulses and sticky lost-event flags.
module pulse_sched #(
    parameter int N   = 4,
    parameter int IW  = 2,
    parameter int GAP = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    pulse_sched_if.slave  bus
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP - 1);

    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  ovf_q, ovf_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pulse_q, pulse_d;
    logic [IW-1:0] sel_q, sel_d;

    logic          eligible_s;
    logic [IW-1:0] grant_idx_s;
    logic [N-1:0]  grant_mask_s;
    logic [N-1:0]  ovf_set_s;

    assign eligible_s = (gap_q == {GW{1'b0}}) && (|pending_q);

    // Rotating first-set search starting at ptr_q.
    always_comb begin : grant_search
        int  idx_v;
        logic found_v;
        grant_idx_s = {IW{1'b0}};
        found_v     = 1'b0;
        idx_v       = 0;
        for (int k = 0; k < N; k++) begin
            idx_v = (int'(ptr_q) + k) % N;
            if (!found_v && pending_q[idx_v]) begin
                grant_idx_s = IW'(idx_v);
                found_v     = 1'b1;
            end else begin
                found_v     = found_v;
            end
        end
    end

    // Next-state: capture, grant, overflow and spacing counter.
    always_comb begin
        grant_mask_s = {N{1'b0}};
        if (eligible_s) begin
            grant_mask_s[grant_idx_s] = 1'b1;
        end else begin
            grant_mask_s = {N{1'b0}};
        end

        // A request on the granted bit re-arms it rather than overflowing.
        ovf_set_s = bus.req & pending_q & ~grant_mask_s;
        pending_d = (pending_q & ~grant_mask_s) | bus.req;
        ovf_d     = (bus.ovf_clr ? {N{1'b0}} : ovf_q) | ovf_set_s;

        if (eligible_s) begin
            pulse_d = 1'b1;
            sel_d   = grant_idx_s;
            gap_d   = GAP_RELOAD;
            if (grant_idx_s == IW'(N - 1)) begin
                ptr_d = {IW{1'b0}};
            end else begin
                ptr_d = grant_idx_s + {{(IW-1){1'b0}}, 1'b1};
            end
        end else begin
            pulse_d = 1'b0;
            sel_d   = sel_q;
            ptr_d   = ptr_q;
            if (gap_q != {GW{1'b0}}) begin
                gap_d = gap_q - {{(GW-1){1'b0}}, 1'b1};
            end else begin
                gap_d = gap_q;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q <= {N{1'b0}};
            ovf_q     <= {N{1'b0}};
            ptr_q     <= {IW{1'b0}};
            gap_q     <= {GW{1'b0}};
            pulse_q   <= 1'b0;
            sel_q     <= {IW{1'b0}};
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            pulse_q   <= pulse_d;
            sel_q     <= sel_d;
        end
    end

    assign bus.pulse   = pulse_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = (gap_q != {GW{1'b0}});
    assign bus.pending = pending_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: a GAP=4 instance driven from a vector table and
// a GAP=1 instance for back-to-back behaviour, plus reset-mid-operation checks.
module tb_pulse_sched;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pulse_sched_if #(.N(4), .IW(2)) if4 ();
    pulse_sched_if #(.N(4), .IW(2)) if1 ();

    pulse_sched #(.N(4), .IW(2), .GAP(4)) dut4 (.clk_i(clk), .reset_i(rst), .bus(if4));
    pulse_sched #(.N(4), .IW(2), .GAP(1)) dut1 (.clk_i(clk), .reset_i(rst), .bus(if1));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       clr;
        logic       pulse;
        logic [1:0] sel;
        logic       busy;
        logic [3:0] pend;
        logic [3:0] ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic [3:0] r, input logic c, input logic p, input logic [1:0] s,
                     input logic b, input logic [3:0] pd, input logic [3:0] o);
        vec_t e;
        e.req = r; e.clr = c; e.pulse = p; e.sel = s; e.busy = b; e.pend = pd; e.ovf = o;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int npulse;
        clk = 1'b0; rst = 1'b1;
        checks = 0; failures = 0;
        if4.req = 4'h0; if4.ovf_clr = 1'b0;
        if1.req = 4'h0; if1.ovf_clr = 1'b0;

        // all requesters at once, issued 0..3 four cycles apart
        v(4'hF,1'b0, 1'b0,2'd0,1'b0,4'hF,4'h0);
        v(4'h0,1'b0, 1'b1,2'd0,1'b1,4'hE,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'hE,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'hE,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b0,4'hE,4'h0);
        v(4'h0,1'b0, 1'b1,2'd1,1'b1,4'hC,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'hC,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'hC,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b0,4'hC,4'h0);
        v(4'h0,1'b0, 1'b1,2'd2,1'b1,4'h8,4'h0);
        v(4'h0,1'b0, 1'b0,2'd2,1'b1,4'h8,4'h0);
        v(4'h0,1'b0, 1'b0,2'd2,1'b1,4'h8,4'h0);
        v(4'h0,1'b0, 1'b0,2'd2,1'b0,4'h8,4'h0);
        v(4'h0,1'b0, 1'b1,2'd3,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd3,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd3,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd3,1'b0,4'h0,4'h0);
        // wrap after grant to 3: 0 then 3
        v(4'h9,1'b0, 1'b0,2'd3,1'b0,4'h9,4'h0);
        v(4'h0,1'b0, 1'b1,2'd0,1'b1,4'h8,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'h8,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'h8,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b0,4'h8,4'h0);
        v(4'h0,1'b0, 1'b1,2'd3,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd3,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd3,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd3,1'b0,4'h0,4'h0);
        // single event on requester 2
        v(4'h4,1'b0, 1'b0,2'd3,1'b0,4'h4,4'h0);
        v(4'h0,1'b0, 1'b1,2'd2,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd2,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd2,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd2,1'b0,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd2,1'b0,4'h0,4'h0);
        // grant to 1, then 0b0011 serves 0 before 1
        v(4'h2,1'b0, 1'b0,2'd2,1'b0,4'h2,4'h0);
        v(4'h0,1'b0, 1'b1,2'd1,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b0,4'h0,4'h0);
        v(4'h3,1'b0, 1'b0,2'd1,1'b0,4'h3,4'h0);
        v(4'h0,1'b0, 1'b1,2'd0,1'b1,4'h2,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'h2,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'h2,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b0,4'h2,4'h0);
        v(4'h0,1'b0, 1'b1,2'd1,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b0,4'h0,4'h0);
        // overflow on requester 1 while busy, then clear
        v(4'h1,1'b0, 1'b0,2'd1,1'b0,4'h1,4'h0);
        v(4'h0,1'b0, 1'b1,2'd0,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'h0,4'h0);
        v(4'h2,1'b0, 1'b0,2'd0,1'b1,4'h2,4'h0);
        v(4'h2,1'b0, 1'b0,2'd0,1'b0,4'h2,4'h2);
        v(4'h0,1'b0, 1'b1,2'd1,1'b1,4'h0,4'h2);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'h0,4'h2);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'h0,4'h2);
        v(4'h0,1'b1, 1'b0,2'd1,1'b0,4'h0,4'h0);
        // ovf_clr on the same edge as a fresh overflow: set wins
        v(4'h3,1'b0, 1'b0,2'd1,1'b0,4'h3,4'h0);
        v(4'h2,1'b1, 1'b1,2'd0,1'b1,4'h2,4'h2);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'h2,4'h2);
        v(4'h0,1'b0, 1'b0,2'd0,1'b1,4'h2,4'h2);
        v(4'h0,1'b0, 1'b0,2'd0,1'b0,4'h2,4'h2);
        v(4'h0,1'b0, 1'b1,2'd1,1'b1,4'h0,4'h2);
        v(4'h0,1'b1, 1'b0,2'd1,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b1,4'h0,4'h0);
        v(4'h0,1'b0, 1'b0,2'd1,1'b0,4'h0,4'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset pulse",   {31'd0, if4.pulse}, 32'd0);
        chk("reset sel",     {30'd0, if4.sel},   32'd0);
        chk("reset busy",    {31'd0, if4.busy},  32'd0);
        chk("reset pending", {28'd0, if4.pending}, 32'd0);
        chk("reset ovf",     {28'd0, if4.ovf},   32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            if4.req = tbl[i].req;
            if4.ovf_clr = tbl[i].clr;
            tick();
            chk($sformatf("row%0d pulse", i),   {31'd0, if4.pulse},   {31'd0, tbl[i].pulse});
            chk($sformatf("row%0d sel", i),     {30'd0, if4.sel},     {30'd0, tbl[i].sel});
            chk($sformatf("row%0d busy", i),    {31'd0, if4.busy},    {31'd0, tbl[i].busy});
            chk($sformatf("row%0d pending", i), {28'd0, if4.pending}, {28'd0, tbl[i].pend});
            chk($sformatf("row%0d ovf", i),     {28'd0, if4.ovf},     {28'd0, tbl[i].ovf});
        end
        if4.req = 4'h0;
        if4.ovf_clr = 1'b0;

        // GAP=1: same-edge request and grant keeps the new event
        if1.req = 4'h4;
        tick();
        chk("g1 c1 pending", {28'd0, if1.pending}, 32'h4);
        chk("g1 c1 pulse",   {31'd0, if1.pulse},   32'd0);
        tick();
        chk("g1 c2 pulse",   {31'd0, if1.pulse},   32'd1);
        chk("g1 c2 sel",     {30'd0, if1.sel},     32'd2);
        chk("g1 c2 pending", {28'd0, if1.pending}, 32'h4);
        if1.req = 4'h0;
        tick();
        chk("g1 c3 pulse",   {31'd0, if1.pulse},   32'd1);
        chk("g1 c3 sel",     {30'd0, if1.sel},     32'd2);
        chk("g1 c3 pending", {28'd0, if1.pending}, 32'h0);
        chk("g1 c3 ovf",     {28'd0, if1.ovf},     32'h0);
        tick();
        chk("g1 c4 pulse",   {31'd0, if1.pulse},   32'd0);
        chk("g1 c4 busy",    {31'd0, if1.busy},    32'd0);

        // GAP=1 back-to-back from ptr=3: 3,0,1,2 on consecutive cycles
        if1.req = 4'hF;
        tick();
        if1.req = 4'h0;
        chk("b2b pending", {28'd0, if1.pending}, 32'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("b2b%0d pulse", k), {31'd0, if1.pulse}, 32'd1);
            chk($sformatf("b2b%0d sel", k),   {30'd0, if1.sel},   32'((k + 3) % 4));
            chk($sformatf("b2b%0d busy", k),  {31'd0, if1.busy},  32'd0);
        end
        tick();
        chk("b2b end pulse", {31'd0, if1.pulse}, 32'd0);

        // reset mid-operation with pending=0b1010 and busy high
        if4.req = 4'h8;
        tick();
        if4.req = 4'hA;
        tick();
        if4.req = 4'h0;
        chk("pre-rst pulse",   {31'd0, if4.pulse},   32'd1);
        chk("pre-rst sel",     {30'd0, if4.sel},     32'd3);
        chk("pre-rst pending", {28'd0, if4.pending}, 32'hA);
        chk("pre-rst busy",    {31'd0, if4.busy},    32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid-rst pulse",   {31'd0, if4.pulse},   32'd0);
        chk("mid-rst sel",     {30'd0, if4.sel},     32'd0);
        chk("mid-rst busy",    {31'd0, if4.busy},    32'd0);
        chk("mid-rst pending", {28'd0, if4.pending}, 32'h0);
        chk("mid-rst ovf",     {28'd0, if4.ovf},     32'h0);
        tick();
        rst = 1'b0;
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (if4.pulse) npulse++;
        end
        chk("post-rst idle pulses", 32'(npulse), 32'd0);
        if4.req = 4'h1;
        tick();
        if4.req = 4'h0;
        chk("post-rst c1 pulse", {31'd0, if4.pulse}, 32'd0);
        tick();
        chk("post-rst c2 pulse", {31'd0, if4.pulse}, 32'd1);
        chk("post-rst c2 sel",   {30'd0, if4.sel},   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
